i281_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the i281 CPU. Sits directly downstream of the 16-word code ROM.

---
 rtl/i281_pkg.sv | 42 ++++
 rtl/i281_code_mux.sv | 17 +
 rtl/i281_fetch_unit.sv | 91 +++++++++
 tb/tb_i281_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/i281_pkg.sv
// Shared i281 fetch-side constants: code store geometry, IR field layout, opcodes, fetch states.
package i281_pkg;

  localparam int CODE_DEPTH = 16;
  localparam int PC_W       = $clog2(CODE_DEPTH);
  localparam int WORD_W     = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_INPUT = 4'h1;
  localparam logic [3:0] OP_MOVE  = 4'h2;
  localparam logic [3:0] OP_LOADI = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_SUBI  = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_LOADF = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_STORF = 4'hB;
  localparam logic [3:0] OP_SHIFT = 4'hC;
  localparam logic [3:0] OP_CMP   = 4'hD;
  localparam logic [3:0] OP_BR    = 4'hE;
  localparam logic [3:0] OP_BRC   = 4'hF;
  // HALT reuses the unconditional-branch opcode; decode tells them apart by imm.
  localparam logic [3:0] OP_HALT  = 4'hE;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    RUN      = 2'd1,
    HALT     = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/i281_code_mux.sv
// Combinational 16:1 code-word select; zero latency, no flow control.
module i281_code_mux
  import i281_pkg::*;
(
  input  logic [CODE_DEPTH*WORD_W-1:0] words,
  input  logic [PC_W-1:0]              addr,
  output logic [WORD_W-1:0]            word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < CODE_DEPTH; i++) begin
      if (addr == PC_W'(i)) word = words[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/i281_fetch_unit.sv
// i281 fetch stage: ROM word -> IR in 1 edge, zero-bubble redirect, halt on consume.
// IR, ir_pc, fetch_pc and count hold while ir_valid is stalled by !ir_ready.
module i281_fetch_unit
  import i281_pkg::*;
#(
  parameter int DEPTH    = CODE_DEPTH,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
)
(
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [15:0]                b0I,
  input  logic [15:0]                b1I,
  input  logic [15:0]                b2I,
  input  logic [15:0]                b3I,
  input  logic [15:0]                b4I,
  input  logic [15:0]                b5I,
  input  logic [15:0]                b6I,
  input  logic [15:0]                b7I,
  input  logic [15:0]                b8I,
  input  logic [15:0]                b9I,
  input  logic [15:0]                b10I,
  input  logic [15:0]                b11I,
  input  logic [15:0]                b12I,
  input  logic [15:0]                b13I,
  input  logic [15:0]                b14I,
  input  logic [15:0]                b15I,
  output logic [15:0]                ir,
  output logic [$clog2(DEPTH)-1:0]   ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  input  logic                       redirect,
  input  logic [7:0]                 redirect_off,
  input  logic                       halt_req,
  output logic                       halted,
  output logic [CNT_W-1:0]           fetch_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t  state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] target;
  logic [AW-1:0] sel;
  logic [15:0]   rom_word;
  logic          consume;

  assign consume = ir_valid & ir_ready;
  // Sign extension is irrelevant after truncation to AW bits, so plain 8-bit add suffices.
  assign target  = AW'({{(8-AW){1'b0}}, ir_pc} + 8'd1 + redirect_off);
  assign sel     = (consume & redirect) ? target : fetch_pc;

  i281_code_mux u_code_mux (
    .words ({b15I, b14I, b13I, b12I, b11I, b10I, b9I, b8I,
             b7I,  b6I,  b5I,  b4I,  b3I,  b2I,  b1I, b0I}),
    .addr  (sel),
    .word  (rom_word)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= RST_WAIT;
      fetch_pc    <= AW'(START_PC);
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        RST_WAIT: state <= RUN;
        RUN: begin
          if (consume & halt_req) begin
            ir_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= HALT;
          end else if (!ir_valid | consume) begin
            ir       <= rom_word;
            ir_pc    <= sel;
            ir_valid <= 1'b1;
            fetch_pc <= sel + AW'(1);
            if (fetch_count != {CNT_W{1'b1}}) fetch_count <= fetch_count + 1'b1;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_i281_fetch_unit.sv
// Scoreboard bench for i281_fetch_unit: ROM word N = 16'h1000+N, loads queued by address.
module tb_i281_fetch_unit;
  import i281_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] b [16];
  logic [15:0] ir;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_off = 8'h00;
  logic        halt_req = 1'b0;
  logic        halted;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_state_t m_state;
  logic         m_valid;
  logic         m_halted;
  logic [15:0]  m_cnt;
  logic [3:0]   m_fpc;
  logic [3:0]   m_irpc;
  logic [3:0]   q[$];

  initial begin
    for (int i = 0; i < 16; i++) b[i] = 16'h1000 + 16'(i);
  end

  always #5 Clock = ~Clock;

  i281_fetch_unit dut (
    .Clock(Clock), .Reset(Reset),
    .b0I(b[0]),   .b1I(b[1]),   .b2I(b[2]),   .b3I(b[3]),
    .b4I(b[4]),   .b5I(b[5]),   .b6I(b[6]),   .b7I(b[7]),
    .b8I(b[8]),   .b9I(b[9]),   .b10I(b[10]), .b11I(b[11]),
    .b12I(b[12]), .b13I(b[13]), .b14I(b[14]), .b15I(b[15]),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_off(redirect_off), .halt_req(halt_req),
    .halted(halted), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ir_ready = 1'b0; redirect = 1'b0; redirect_off = 8'h00; halt_req = 1'b0;
    q.delete();
    m_state = RST_WAIT; m_valid = 1'b0; m_halted = 1'b0;
    m_cnt = 16'h0; m_fpc = 4'd0; m_irpc = 4'd0;
    repeat (2) @(negedge Clock);
    check("rst_valid",  32'(ir_valid),    32'h0);
    check("rst_ir",     32'(ir),          32'h0);
    check("rst_pc",     32'(ir_pc),       32'h0);
    check("rst_halted", 32'(halted),      32'h0);
    check("rst_count",  32'(fetch_count), 32'h0);
    Reset = 1'b0;
  endtask

  // One cycle: drive at negedge, compare current outputs, advance model, step edge.
  task automatic cyc(input logic rdy, input logic rd, input logic [7:0] off, input logic hq);
    logic       cons;
    logic [3:0] sel;
    logic [3:0] exp_pc;
    ir_ready = rdy; redirect = rd; redirect_off = off; halt_req = hq;
    check("valid",  32'(ir_valid),    32'(m_valid));
    check("halted", 32'(halted),      32'(m_halted));
    check("count",  32'(fetch_count), 32'(m_cnt));
    if (m_valid) begin
      if (q.size() == 0) check("sb_empty", 32'(q.size()), 32'h1);
      else begin
        exp_pc = q[0];
        check("ir",    32'(ir),    32'(16'h1000 + 16'(exp_pc)));
        check("ir_pc", 32'(ir_pc), 32'(exp_pc));
      end
    end
    cons = m_valid & rdy;
    case (m_state)
      RST_WAIT: m_state = RUN;
      RUN: begin
        if (cons && q.size() > 0) void'(q.pop_front());
        if (cons && hq) begin
          m_valid = 1'b0; m_halted = 1'b1; m_state = HALT;
        end else if (!m_valid || cons) begin
          sel = (cons && rd) ? 4'(m_irpc + 4'd1 + off[3:0]) : m_fpc;
          q.push_back(sel);
          m_irpc = sel; m_fpc = sel + 4'd1; m_valid = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      default: ;
    endcase
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic run_to(input logic [3:0] pc);
    for (int i = 0; i < 40; i++) begin
      if (m_valid && m_irpc == pc) return;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
    end
    check("run_to_timeout", 32'(m_irpc), 32'(pc));
  endtask

  initial begin
    // Sequential fetch with wrap; redirect/halt with nothing valid are ignored.
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("no_early_valid", 32'(ir_valid), 32'h0);
    cyc(1'b1, 1'b1, 8'h07, 1'b1);
    check("first_valid", 32'(ir_valid), 32'h1);
    check("first_ir",    32'(ir),       32'h1000);
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("wrap_ir", 32'(ir), 32'h1001);

    // Hold at pc 5, with redirect/halt ignored while stalled.
    run_to(4'd5);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("hold_ir", 32'(ir), 32'h1005);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("release_ir", 32'(ir), 32'h1006);

    // Redirect backwards across zero: 2 + 1 - 5 = 14.
    run_to(4'd2);
    cyc(1'b1, 1'b1, 8'hFB, 1'b0);
    check("redir_ir", 32'(ir), 32'h100E);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("redir_next", 32'(ir), 32'h100F);
    cyc(1'b1, 1'b1, 8'h7F, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);

    // Halt beats redirect; everything ignored afterwards.
    cyc(1'b1, 1'b1, 8'h05, 1'b1);
    check("halt_valid",  32'(ir_valid), 32'h0);
    check("halt_halted", 32'(halted),   32'h1);
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));

    // Asynchronous reset between edges while holding at pc 9.
    do_reset();
    run_to(4'd9);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check("arst_valid", 32'(ir_valid),    32'h0);
    check("arst_ir",    32'(ir),          32'h0);
    check("arst_pc",    32'(ir_pc),       32'h0);
    check("arst_count", 32'(fetch_count), 32'h0);
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("restart_ir", 32'(ir), 32'h1000);

    // Counter saturation: a load every cycle runs past 16'hFFFF.
    for (int i = 0; i < 65540; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("sat_count", 32'(fetch_count), 32'h0000FFFF);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("sat_hold", 32'(fetch_count), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
